// File: rtl/serial_pe_pkg.sv
// Shared constants and types for the serial MAC PE and its job sequencer.
package serial_pe_pkg;

  localparam int OP_W  = 16;  // operand width (neuron, weight)
  localparam int ACC_W = 32;  // accumulator / result width

  // Bit positions inside the 2-bit PE control field
  localparam int CTL_FIRST = 0;  // first beat: load accumulator
  localparam int CTL_LAST  = 1;  // last beat: emit result

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/serial_pe.sv
// Serial multiply-accumulate PE: one operand pair per clock. A first beat
// reloads the accumulator; a last beat registers the finished sum for one cycle.
module serial_pe
  import serial_pe_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [OP_W-1:0] neuron_i,
  input  logic signed [OP_W-1:0] weight_i,
  input  logic [1:0]             ctl_i,
  input  logic                   vld_i,
  output logic [ACC_W-1:0]       result_o,
  output logic                   vld_o
);

  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0]        res_q;
  logic                    vld_q;

  // Full-precision product, then accumulate with natural 32-bit wrap
  always_comb begin
    prod  = ACC_W'(neuron_i) * ACC_W'(weight_i);
    acc_d = ctl_i[CTL_FIRST] ? prod : acc_q + prod;
  end

  // Accumulator and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      res_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= vld_i & ctl_i[CTL_LAST];
      if (vld_i) begin
        acc_q <= acc_d;
        if (ctl_i[CTL_LAST]) res_q <= acc_d;
      end
    end
  end

  assign result_o = res_q;
  assign vld_o    = vld_q;

endmodule

// File: rtl/serial_pe_agen.sv
// Address generator: beat/output counters, neuron and weight read pointers,
// and the first/last/end-of-job flags for the beat currently being issued.
module serial_pe_agen
  import serial_pe_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              adv_i,
  input  logic [LEN_W-1:0]  vec_len_i,
  input  logic [OUT_W-1:0]  out_cnt_i,
  input  logic [ADDR_W-1:0] nrn_base_i,
  input  logic [ADDR_W-1:0] wgt_base_i,
  output logic [ADDR_W-1:0] nrn_addr_o,
  output logic [ADDR_W-1:0] wgt_addr_o,
  output logic              first_o,
  output logic              last_o,
  output logic              end_o
);

  logic [LEN_W-1:0]  len_q, len_d, k_q, k_d;
  logic [OUT_W-1:0]  cnt_q, cnt_d, o_q, o_d;
  logic [ADDR_W-1:0] nbase_q, nbase_d, nptr_q, nptr_d, wptr_q, wptr_d;

  assign first_o    = (k_q == '0);
  assign last_o     = (k_q == len_q - LEN_W'(1));
  assign end_o      = last_o && (o_q == cnt_q - OUT_W'(1));
  assign nrn_addr_o = nptr_q;
  assign wgt_addr_o = wptr_q;

  // Next-state: latch job on load; on each beat step k, wrap to next output.
  // The weight pointer runs linearly, so wgt_base + o*N + k needs no multiply.
  always_comb begin
    len_d   = len_q;
    cnt_d   = cnt_q;
    nbase_d = nbase_q;
    k_d     = k_q;
    o_d     = o_q;
    nptr_d  = nptr_q;
    wptr_d  = wptr_q;
    if (load_i) begin
      len_d   = vec_len_i;
      cnt_d   = out_cnt_i;
      nbase_d = nrn_base_i;
      k_d     = '0;
      o_d     = '0;
      nptr_d  = nrn_base_i;
      wptr_d  = wgt_base_i;
    end else if (adv_i) begin
      wptr_d = wptr_q + ADDR_W'(1);
      if (last_o) begin
        k_d    = '0;
        o_d    = o_q + OUT_W'(1);
        nptr_d = nbase_q;
      end else begin
        k_d    = k_q + LEN_W'(1);
        nptr_d = nptr_q + ADDR_W'(1);
      end
    end
  end

  // Counter and pointer state
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= '0;
      cnt_q   <= '0;
      nbase_q <= '0;
      k_q     <= '0;
      o_q     <= '0;
      nptr_q  <= '0;
      wptr_q  <= '0;
    end else begin
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      nbase_q <= nbase_d;
      k_q     <= k_d;
      o_q     <= o_d;
      nptr_q  <= nptr_d;
      wptr_q  <= wptr_d;
    end
  end

endmodule

// File: rtl/serial_pe_ctrl.sv
// Job sequencer for the serial PE: streams operand pairs from the neuron and
// weight buffers into the PE and writes each returned dot product out.
module serial_pe_ctrl
  import serial_pe_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10,
  parameter int OUT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LEN_W-1:0]       vec_len,
  input  logic [OUT_W-1:0]       out_cnt,
  input  logic [ADDR_W-1:0]      nrn_base,
  input  logic [ADDR_W-1:0]      wgt_base,
  output logic                   busy,
  output logic                   done,
  output logic                   nrn_rd_en,
  output logic [ADDR_W-1:0]      nrn_rd_addr,
  input  logic signed [OP_W-1:0] nrn_rd_data,
  output logic                   wgt_rd_en,
  output logic [ADDR_W-1:0]      wgt_rd_addr,
  input  logic signed [OP_W-1:0] wgt_rd_data,
  output logic signed [OP_W-1:0] pe_neuron,
  output logic signed [OP_W-1:0] pe_weight,
  output logic [1:0]             pe_ctl,
  output logic                   pe_vld,
  input  logic [ACC_W-1:0]       pe_result,
  input  logic                   pe_vld_o,
  output logic                   res_wr_en,
  output logic [OUT_W-1:0]       res_wr_addr,
  output logic [ACC_W-1:0]       res_wr_data
);

  state_e           state_q, state_d;
  logic [OUT_W-1:0] m_q, m_d;
  logic [OUT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             rd_en_q, first_q, last_q;

  logic issue, job_ok, load, wr_fire;
  logic ag_first, ag_last, ag_end;

  assign issue   = (state_q == ST_RUN);
  assign job_ok  = (vec_len != '0) && (out_cnt != '0);
  assign load    = (state_q == ST_IDLE) && start && job_ok;
  // A result arriving during reset is dropped so an aborted job writes nothing
  assign wr_fire = pe_vld_o && (state_q != ST_IDLE) && !rst;

  serial_pe_agen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W),
    .OUT_W  (OUT_W)
  ) u_agen (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .adv_i      (issue),
    .vec_len_i  (vec_len),
    .out_cnt_i  (out_cnt),
    .nrn_base_i (nrn_base),
    .wgt_base_i (wgt_base),
    .nrn_addr_o (nrn_rd_addr),
    .wgt_addr_o (wgt_rd_addr),
    .first_o    (ag_first),
    .last_o     (ag_last),
    .end_o      (ag_end)
  );

  // Job FSM; DRAIN exits once the write count (including this cycle) hits M
  always_comb begin
    state_d  = state_q;
    m_d      = load ? out_cnt : m_q;
    wr_cnt_d = load ? '0 : wr_cnt_q + OUT_W'(wr_fire);
    case (state_q)
      ST_IDLE:  if (start) state_d = job_ok ? ST_RUN : ST_DONE;
      ST_RUN:   if (ag_end) state_d = ST_DRAIN;
      ST_DRAIN: if (wr_cnt_d == m_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, job size, write counter and the one-cycle issue register that
  // lines first/last up with the read data coming back from the buffers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      m_q      <= '0;
      wr_cnt_q <= '0;
      rd_en_q  <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      wr_cnt_q <= wr_cnt_d;
      rd_en_q  <= issue;
      first_q  <= issue & ag_first;
      last_q   <= issue & ag_last;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign nrn_rd_en = issue;
  assign wgt_rd_en = issue;

  // Operand stream: data passes straight from the buffers, zeroed when idle
  always_comb begin
    pe_vld             = rd_en_q;
    pe_ctl             = '0;
    pe_ctl[CTL_FIRST]  = rd_en_q & first_q;
    pe_ctl[CTL_LAST]   = rd_en_q & last_q;
    pe_neuron          = rd_en_q ? nrn_rd_data : '0;
    pe_weight          = rd_en_q ? wgt_rd_data : '0;
  end

  assign res_wr_en   = wr_fire;
  assign res_wr_addr = wr_cnt_q;
  assign res_wr_data = pe_result;

endmodule

// File: tb/tb_serial_pe_ctrl.sv
// Directed bench: serial_pe_ctrl + serial_pe + neuron/weight/result SRAMs.
module tb_serial_pe_ctrl;
  import serial_pe_pkg::*;

  localparam int ADDR_W = 10, LEN_W = 10, OUT_W = 8;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [LEN_W-1:0]  vec_len  = '0;
  logic [OUT_W-1:0]  out_cnt  = '0;
  logic [ADDR_W-1:0] nrn_base = '0, wgt_base = '0;
  logic busy, done, nrn_rd_en, wgt_rd_en, pe_vld, pe_vld_o, res_wr_en;
  logic [ADDR_W-1:0] nrn_rd_addr, wgt_rd_addr;
  logic signed [OP_W-1:0] nrn_rd_data, wgt_rd_data, pe_neuron, pe_weight;
  logic [1:0] pe_ctl;
  logic [ACC_W-1:0] pe_result, res_wr_data;
  logic [OUT_W-1:0] res_wr_addr;

  logic signed [OP_W-1:0] nrn_mem [0:1023];
  logic signed [OP_W-1:0] wgt_mem [0:1023];
  logic [ACC_W-1:0]       res_mem [0:255];

  always #5 clk = ~clk;

  serial_pe_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .out_cnt(out_cnt),
    .nrn_base(nrn_base), .wgt_base(wgt_base), .busy(busy), .done(done),
    .nrn_rd_en(nrn_rd_en), .nrn_rd_addr(nrn_rd_addr), .nrn_rd_data(nrn_rd_data),
    .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
    .pe_neuron(pe_neuron), .pe_weight(pe_weight), .pe_ctl(pe_ctl), .pe_vld(pe_vld),
    .pe_result(pe_result), .pe_vld_o(pe_vld_o),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data)
  );

  serial_pe u_pe (
    .clk(clk), .rst(rst), .neuron_i(pe_neuron), .weight_i(pe_weight),
    .ctl_i(pe_ctl), .vld_i(pe_vld), .result_o(pe_result), .vld_o(pe_vld_o)
  );

  // Behavioural synchronous-read buffers and result buffer
  always_ff @(posedge clk) if (nrn_rd_en) nrn_rd_data <= nrn_mem[nrn_rd_addr];
  always_ff @(posedge clk) if (wgt_rd_en) wgt_rd_data <= wgt_mem[wgt_rd_addr];
  always_ff @(posedge clk) if (res_wr_en) res_mem[res_wr_addr] <= res_wr_data;

  int npass = 0, nchk = 0;

  // Per-job observations
  int done_cyc, busy_cnt, busy_first, busy_last;
  int rd_cnt, rd_first, rd_last, vld_cnt, vld_first, vld_last;
  int ctl_bad, zero_bad, addr_bad, wr_n;
  int wr_cyc [16];
  logic [ACC_W-1:0]  wr_dat [16];
  logic [ADDR_W-1:0] na_log [64];
  logic [ADDR_W-1:0] wa_log [64];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic sample(input int c, input int n);
    logic [1:0] exp_ctl;
    int k;
    if (busy) begin
      if (busy_cnt == 0) busy_first = c;
      busy_last = c;
      busy_cnt++;
    end
    if (done && done_cyc < 0) done_cyc = c;
    if (nrn_rd_en) begin
      if (rd_cnt == 0) rd_first = c;
      rd_last = c;
      if (rd_cnt < 64) begin
        na_log[rd_cnt] = nrn_rd_addr;
        wa_log[rd_cnt] = wgt_rd_addr;
      end
      rd_cnt++;
    end
    if (pe_vld) begin
      if (vld_cnt == 0) vld_first = c;
      vld_last = c;
      vld_cnt++;
      k = (n > 0) ? (c - 2) % n : 0;
      exp_ctl = {(k == n - 1), (k == 0)};
      if (pe_ctl !== exp_ctl) ctl_bad++;
    end else if (pe_neuron !== '0 || pe_weight !== '0 || pe_ctl !== 2'b00) begin
      zero_bad++;
    end
    if (res_wr_en) begin
      if (res_wr_addr !== OUT_W'(wr_n)) addr_bad++;
      if (wr_n < 16) begin
        wr_cyc[wr_n] = c;
        wr_dat[wr_n] = res_wr_data;
      end
      wr_n++;
    end
  endtask

  // Launch a job in cycle 0 and observe until two cycles after done
  task automatic run_job(input int n, input int m, input int nb, input int wb,
                         input int again_at);
    done_cyc = -1; busy_cnt = 0; busy_first = -1; busy_last = -1;
    rd_cnt = 0; rd_first = -1; rd_last = -1;
    vld_cnt = 0; vld_first = -1; vld_last = -1;
    ctl_bad = 0; zero_bad = 0; addr_bad = 0; wr_n = 0;
    vec_len = LEN_W'(n); out_cnt = OUT_W'(m);
    nrn_base = ADDR_W'(nb); wgt_base = ADDR_W'(wb);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      sample(c, n);
      start = (c == again_at);
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
      step();
    end
    start = 1'b0;
  endtask

  initial begin
    int w;
    for (int i = 0; i < 1024; i++) begin
      nrn_mem[i] = '0;
      wgt_mem[i] = '0;
    end
    nrn_mem[0] = 1;  nrn_mem[1] = 2;  nrn_mem[2] = 3;
    wgt_mem[0] = 4;  wgt_mem[1] = 5;  wgt_mem[2] = 6;
    wgt_mem[3] = -1; wgt_mem[4] = -1; wgt_mem[5] = -1;
    nrn_mem[100] = 7;
    for (int i = 0; i < 4; i++) wgt_mem[200 + i] = OP_W'(i + 1);
    nrn_mem[300] = -16'sd32768; nrn_mem[301] = -16'sd32768;
    wgt_mem[400] = -16'sd32768; wgt_mem[401] = -16'sd32768;
    nrn_mem[1022] = 1; nrn_mem[1023] = 1; wgt_mem[1023] = 2;

    // Reset state
    rst = 1'b1;
    step(); step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_en", 32'({nrn_rd_en, wgt_rd_en}), 0);
    chk("rst_pe", 32'({pe_vld, pe_ctl}), 0);
    chk("rst_wr_en", 32'(res_wr_en), 0);
    chk("rst_addr", 32'({nrn_rd_addr, wgt_rd_addr, res_wr_addr}), 0);
    rst = 1'b0;
    step();

    // N=3, M=2
    run_job(3, 2, 0, 0, -1);
    chk("t1_res0", wr_dat[0], 32);
    chk("t1_res1", wr_dat[1], -6);
    chk("t1_wr_cyc0", wr_cyc[0], 5);
    chk("t1_wr_cyc1", wr_cyc[1], 8);
    chk("t1_wr_n", wr_n, 2);
    chk("t1_done", done_cyc, 9);
    chk("t1_busy", {busy_first[7:0], busy_last[7:0], busy_cnt[7:0]}, {8'd1, 8'd9, 8'd9});
    chk("t1_reads", {rd_first[7:0], rd_last[7:0], rd_cnt[7:0]}, {8'd1, 8'd6, 8'd6});
    chk("t1_vld", {vld_first[7:0], vld_last[7:0], vld_cnt[7:0]}, {8'd2, 8'd7, 8'd6});
    chk("t1_ctl", ctl_bad, 0);
    chk("t1_zero", zero_bad, 0);
    chk("t1_waddr", addr_bad, 0);
    chk("t1_mem1", res_mem[1], -6);

    // N=1, M=4
    run_job(1, 4, 100, 200, -1);
    for (int i = 0; i < 4; i++) chk("t2_res", wr_dat[i], 7 * (i + 1));
    chk("t2_wr_cyc3", wr_cyc[3], 6);
    chk("t2_ctl", ctl_bad, 0);
    chk("t2_done", done_cyc, 7);
    chk("t2_waddr", addr_bad, 0);

    // Degenerate jobs
    run_job(0, 5, 0, 0, -1);
    chk("t3a_done", done_cyc, 1);
    chk("t3a_io", {rd_cnt[15:0], wr_n[15:0]}, 0);
    chk("t3a_busy", busy_cnt, 1);
    run_job(5, 0, 0, 0, -1);
    chk("t3b_done", done_cyc, 1);
    chk("t3b_io", {rd_cnt[15:0], wr_n[15:0]}, 0);
    chk("t3b_busy", busy_cnt, 1);

    // Extreme operands: 2 * 2^30 wraps to 0x8000_0000
    run_job(2, 1, 300, 400, -1);
    chk("t4_res", wr_dat[0], 32'h8000_0000);
    chk("t4_done", done_cyc, 5);

    // Address wrap
    run_job(4, 1, 1022, 1023, -1);
    chk("t5_na", {na_log[0], na_log[1], na_log[2], na_log[3]},
        {10'd1022, 10'd1023, 10'd0, 10'd1});
    chk("t5_wa", {wa_log[0], wa_log[1], wa_log[2], wa_log[3]},
        {10'd1023, 10'd0, 10'd1, 10'd2});
    chk("t5_res", wr_dat[0], 23);

    // start during RUN is ignored
    run_job(3, 2, 0, 0, 3);
    chk("t6_res0", wr_dat[0], 32);
    chk("t6_res1", wr_dat[1], -6);
    chk("t6_done", done_cyc, 9);
    chk("t6_rd", rd_cnt, 6);

    // rst mid-RUN aborts
    vec_len = 3; out_cnt = 2; nrn_base = 0; wgt_base = 0;
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    rst = 1'b1;
    w = res_wr_en ? 1 : 0;
    step();
    chk("t7_out", 32'({busy, done, nrn_rd_en, wgt_rd_en, pe_vld, pe_ctl, res_wr_en}), 0);
    chk("t7_ops", 32'({pe_neuron, pe_weight}), 0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (res_wr_en || busy) w++;
    end
    chk("t7_quiet", w, 0);

    // Fresh job after reset
    run_job(3, 2, 0, 0, -1);
    chk("t8_res0", wr_dat[0], 32);
    chk("t8_res1", wr_dat[1], -6);
    chk("t8_done", done_cyc, 9);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
